ex_div: RTL
===========

// Module: ex_div
// PURPOSE
//  Iterative radix-2 restoring divider in the EX stage. It executes div.w/mod.w/div.wu/mod.wu issued through the ID/EX register.
//  It holds the ID/EX and earlier stages through stallreq_o until the quotient and remainder are ready.
//  EX selects quotient or remainder from result_o. A flush from ctrl aborts it through annul_i.
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are WIDTH bits each
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset, asynchronous, active-low
//  start_i       in   1        EX holds a divide op; held high until ready_o is seen
//  annul_i       in   1        pipeline flush; abort the operation in progress
//  signed_div_i  in   1        1 = two's-complement operands, 0 = unsigned
//  opdata1_i     in   WIDTH    dividend (ex_reg1)
//  opdata2_i     in   WIDTH    divisor  (ex_reg2)
//  result_o      out  2*WIDTH  {remainder, quotient}
//  ready_o       out  1        result_o valid this cycle
//  stallreq_o    out  1        request ctrl to stall IF/ID/EX
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, cnt=0, result_o=0, ready_o=0, internal operands=0. stallreq_o is forced to 0 while rst is low.
//  stallreq_o = start_i & ~annul_i & (state != END); combinational, no added cycle.
//  FSM states: IDLE, DIVZERO, ON, END. annul_i=1 in any state: next state is IDLE, ready_o=0, result_o holds its value.
//   IDLE: on start_i & ~annul_i, operands are latched.
//     opdata2_i==0: go to DIVZERO.
//     Otherwise: latch |dividend| and |divisor| (magnitude only if signed_div_i), clear partial remainder, cnt=0, go to ON.
//   ON: one restoring step per cycle.
//     Shift {rem,quo} left by 1, trial-subtract the divisor from rem (WIDTH+1 bits).
//     Non-negative difference: keep it, set quo[0]=1. Negative: restore rem, set quo[0]=0.
//     cnt increments each step. At cnt==WIDTH-1 the last step completes: apply sign fix-up, register result_o, go to END.
//   DIVZERO: result_o = {opdata1 latched, {WIDTH{1'b1}}}; go to END.
//   END: ready_o=1, result_o stable.
//     Stay in END while start_i=1; go to IDLE when start_i=0. ready_o drops the cycle after leaving END.
//  Latency: start_i sampled at edge 0.
//   Nonzero divisor: ready_o is high WIDTH+1 edges later (edge 33 for WIDTH=32).
//   Zero divisor: ready_o is high 2 edges later.
//  Sign rules (signed_div_i=1):
//   quotient is negated if the operand signs differ; remainder takes the dividend's sign.
//   Negation is two's complement on WIDTH bits, so |-2^(W-1)| = 2^(W-1) unsigned.
//   Overflow case -2^(W-1) / -1 yields quotient 0x8000_0000 and remainder 0; no trap.
//  Operands are sampled only in IDLE. Changes on opdata*_i during ON/END are ignored.
//  start_i & annul_i in the same IDLE cycle: annul wins and no operation starts.
//  New start while in END with start_i still high is impossible by protocol. start_i must drop for at least one cycle between operations.
//  Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. No partial result is ever presented.
// TESTING
//  1 unsigned 100/7, start at edge 0:
//    stallreq_o=1 on edges 0..32, ready_o=1 at edge 33, result_o={32'd2, 32'd14}.
//    Drop start_i: ready_o=0 next edge.
//  2 signed -7/2:
//    result_o={32'hFFFF_FFFF, 32'hFFFF_FFFD}.
//  3 signed 7/-2:
//    result_o={32'd1, 32'hFFFF_FFFD}.
//  4 x/0 with x=0x1234_5678 (both signed and unsigned):
//    ready_o at edge 2, result_o={32'h1234_5678, 32'hFFFF_FFFF}.
//  5 signed 0x8000_0000 / 0xFFFF_FFFF:
//    result_o={32'd0, 32'h8000_0000}, ready_o at edge 33.
//  6 annul_i pulsed at edge 10 of an operation:
//    IDLE next edge, ready_o never rises, stallreq_o=0.
//    Then start 9/3: result {0, 3} at its edge 33.
//    Repeat with rst pulsed low mid-ON: all outputs 0 asynchronously, identical restart result.

Source files
------------

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (div.w/mod.w/div.wu/mod.wu).
// Holds earlier stages through stallreq_o until {remainder, quotient} is presented on result_o.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   abs1, abs2;

    always_comb begin
        abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

        // Trial subtract on WIDTH+1 bits; the borrow bit decides keep vs restore.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor_q};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_sh[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dividend_d = opdata1_i;
                    neg_quo_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        divisor_d = abs2;
                        quo_d     = abs1;
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_ON;
                    end
                end
            end
            S_ON: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = {(neg_rem_q ? (~step_rem + 1'b1) : step_rem),
                                (neg_quo_q ? (~step_quo + 1'b1) : step_quo)};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_DIVZERO: begin
                result_d = {dividend_q, {WIDTH{1'b1}}};
                ready_d  = 1'b1;
                state_d  = S_END;
            end
            S_END: begin
                if (!start_i) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wins over everything, including a start seen in the same IDLE cycle.
        if (annul_i) begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = rst & start_i & ~annul_i & (state_q != S_END);

endmodule
